gelu_pwl_interp: RTL and testbench

Streaming GELU evaluator that drives the dual-port GELU LUT ROM and consumes its registered outputs. Each accepted input is classified against the table range. In-range inputs read two adjacent LUT breakpoints in the same cycle, one per ROM port, and the block linearly interpolates between them. Results leave on a valid/ready stream toward the FPU writeback path.

---
 rtl/gelu_pwl_interp.sv | 155 +++++++++++++++
 tb/tb_gelu_pwl_interp.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gelu_pwl_interp.sv
// Streaming GELU evaluator: piecewise-linear interpolation between two adjacent
// breakpoints of a dual-port GELU LUT ROM, 3-stage valid/ready pipeline.
module gelu_pwl_interp #(
  parameter int IN_W       = 16,
  parameter int FRAC_IN    = 12,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 20,
  parameter int SEG_SHIFT  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] lut_addr_a,
  output logic [ADDR_WIDTH-1:0] lut_addr_b,
  input  logic [DATA_WIDTH-1:0] lut_q_a,
  input  logic [DATA_WIDTH-1:0] lut_q_b
);

  localparam int TW = IN_W + 1;
  localparam int PW = DATA_WIDTH + 1 + SEG_SHIFT + 1;
  // Table starts at -(half the table span); x + OFFSET maps the table onto 0..SPAN.
  localparam int OFFSET_I = 2 ** (ADDR_WIDTH - 1 + SEG_SHIFT);
  localparam int SPAN_I   = (2 ** ADDR_WIDTH - 1) * (2 ** SEG_SHIFT);
  localparam logic signed [PW:0] Y_MAX = (PW + 1)'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [PW:0] Y_MIN = (PW + 1)'(-(2 ** (DATA_WIDTH - 1)));

  typedef enum logic [1:0] {
    CLS_MID  = 2'd0,
    CLS_LOW  = 2'd1,
    CLS_HIGH = 2'd2
  } cls_e;

  logic                  s1Valid_q, s2Valid_q, s3Valid_q;
  logic                  s1Ready, s2Ready, s3Ready, accept;

  cls_e                  s1Cls_q, s2Cls_q, cls_d;
  logic [SEG_SHIFT-1:0]  s1Frac_q;
  logic [IN_W-1:0]       s1X_q, s2X_q;
  logic [ADDR_WIDTH-1:0] s1AddrA_q, s1AddrB_q, addrA_d, addrB_d;

  logic [DATA_WIDTH-1:0] s2Base_q;
  logic signed [PW-1:0]  s2Prod_q, prod_d;
  logic [DATA_WIDTH-1:0] y_q, y_d;

  logic signed [TW-1:0]         tIn;
  logic                         isLow, isHigh;
  logic [ADDR_WIDTH-1:0]        idxIn;
  logic signed [DATA_WIDTH:0]   diff;
  logic signed [PW-1:0]         shifted;
  logic signed [PW:0]           sum;

  assign s3Ready  = !s3Valid_q | out_ready;
  assign s2Ready  = !s2Valid_q | s3Ready;
  assign s1Ready  = !s1Valid_q | s2Ready;
  assign in_ready = s1Ready;
  assign accept   = in_valid & s1Ready;

  assign tIn    = $signed({in_data[IN_W-1], in_data}) + $signed(TW'(OFFSET_I));
  assign isLow  = tIn[TW-1];
  assign isHigh = !isLow && (tIn >= $signed(TW'(SPAN_I)));
  assign idxIn  = tIn[SEG_SHIFT+ADDR_WIDTH-1:SEG_SHIFT];

  always_comb begin
    cls_d   = CLS_MID;
    addrA_d = idxIn;
    addrB_d = idxIn + ADDR_WIDTH'(1);
    if (isLow) begin
      cls_d   = CLS_LOW;
      addrA_d = '0;
      addrB_d = '0;
    end else if (isHigh) begin
      cls_d   = CLS_HIGH;
      addrA_d = '1;
      addrB_d = '1;
    end
  end

  // When nothing is accepted, re-present stage 1's addresses so the ROM data
  // keeps matching stage 1 across stalls.
  assign lut_addr_a = accept ? addrA_d : s1AddrA_q;
  assign lut_addr_b = accept ? addrB_d : s1AddrB_q;

  assign diff   = $signed({lut_q_b[DATA_WIDTH-1], lut_q_b}) - $signed({lut_q_a[DATA_WIDTH-1], lut_q_a});
  assign prod_d = $signed({{(PW-DATA_WIDTH-1){diff[DATA_WIDTH]}}, diff})
                * $signed({{(PW-SEG_SHIFT){1'b0}}, s1Frac_q});

  assign shifted = s2Prod_q >>> SEG_SHIFT;
  assign sum     = $signed({{(PW+1-DATA_WIDTH){s2Base_q[DATA_WIDTH-1]}}, s2Base_q})
                 + $signed({shifted[PW-1], shifted});

  always_comb begin
    y_d = '0;
    case (s2Cls_q)
      CLS_HIGH: y_d = {{(DATA_WIDTH-IN_W){s2X_q[IN_W-1]}}, s2X_q};
      CLS_LOW:  y_d = '0;
      default: begin
        if (sum > Y_MAX)      y_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (sum < Y_MIN) y_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else                  y_d = sum[DATA_WIDTH-1:0];
      end
    endcase
  end

  // Each stage advances when it is empty or the next stage is moving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s2Valid_q <= 1'b0;
      s3Valid_q <= 1'b0;
      s1Cls_q   <= CLS_MID;
      s2Cls_q   <= CLS_MID;
      s1Frac_q  <= '0;
      s1X_q     <= '0;
      s2X_q     <= '0;
      s1AddrA_q <= '0;
      s1AddrB_q <= '0;
      s2Base_q  <= '0;
      s2Prod_q  <= '0;
      y_q       <= '0;
    end else begin
      if (s1Ready) begin
        s1Valid_q <= in_valid;
        if (in_valid) begin
          s1Cls_q   <= cls_d;
          s1Frac_q  <= tIn[SEG_SHIFT-1:0];
          s1X_q     <= in_data;
          s1AddrA_q <= addrA_d;
          s1AddrB_q <= addrB_d;
        end
      end
      if (s2Ready) begin
        s2Valid_q <= s1Valid_q;
        if (s1Valid_q) begin
          s2Base_q <= lut_q_a;
          s2Prod_q <= prod_d;
          s2Cls_q  <= s1Cls_q;
          s2X_q    <= s1X_q;
        end
      end
      if (s3Ready) begin
        s3Valid_q <= s2Valid_q;
        if (s2Valid_q) y_q <= y_d;
      end
    end
  end

  assign out_valid = s3Valid_q;
  assign out_data  = y_q;

endmodule

// File: tb/tb_gelu_pwl_interp.sv
// Self-checking bench for gelu_pwl_interp: ROM model, scoreboard of expected
// results, and per-scenario tasks with inline checks.
module tb_gelu_pwl_interp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data;
  logic [19:0] out_data, lut_q_a, lut_q_b;
  logic [3:0]  lut_addr_a, lut_addr_b;

  int checks = 0;
  int failures = 0;

  logic signed [19:0] lut [16];
  int geluTab [16] = '{-1, -3, -17, -64, -186, -410, -650, -632,
                       0, 1416, 3446, 5734, 8006, 10176, 12271, 14333};
  logic [19:0] expQ [$];

  typedef struct {
    int          mode;
    logic [15:0] x;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [19:0] y;
  } vec_t;
  vec_t vecs [11];

  gelu_pwl_interp dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .lut_addr_a(lut_addr_a), .lut_addr_b(lut_addr_b),
    .lut_q_a(lut_q_a), .lut_q_b(lut_q_b)
  );

  always #5 clk = ~clk;

  // Dual-port synchronous ROM, data one cycle after the address.
  always @(posedge clk) begin
    lut_q_a <= lut[lut_addr_a];
    lut_q_b <= lut[lut_addr_b];
  end

  function automatic logic [19:0] model(input logic [15:0] x);
    int xs, t, idx, frac, base, diff, y;
    longint p, q;
    xs = int'($signed(x));
    if (xs < -16384) return 20'd0;
    if (xs >= 14336) return 20'(xs);
    t    = xs + 16384;
    idx  = t / 2048;
    frac = t % 2048;
    base = int'(lut[idx[3:0]]);
    diff = int'(lut[4'(idx + 1)]) - base;
    p    = longint'(diff) * longint'(frac);
    if (p >= 0) q = p / 2048;
    else        q = -((-p + 2047) / 2048);
    y = base + int'(q);
    if (y > 524287)  y = 524287;
    if (y < -524288) y = -524288;
    return 20'(y);
  endfunction

  task automatic load_lut(input int mode);
    for (int k = 0; k < 16; k++) begin
      case (mode)
        0:       lut[k] = 20'(k * 4096);
        1:       lut[k] = 20'(-k * 4096);
        2:       lut[k] = 20'(geluTab[k]);
        3:       lut[k] = 20'(k * 4096 + 100);
        default: lut[k] = 20'(-k * 3000);
      endcase
    end
  endtask

  // Scoreboard: sample just before each rising edge, push on accept, pop on output handshake.
  logic        sampAcc, sampPop;
  logic [19:0] sampOut, expVal;
  logic [15:0] sampIn;
  always begin
    @(negedge clk);
    #4;
    sampAcc = rst_n && in_valid && in_ready;
    sampPop = rst_n && out_valid && out_ready;
    sampOut = out_data;
    sampIn  = in_data;
    @(posedge clk);
    if (rst_n) begin
      if (sampPop) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL scoreboard_extra: got out_data=%h, no result expected", sampOut);
        end else begin
          expVal = expQ.pop_front();
          if (sampOut !== expVal) begin
            failures++;
            $display("[TB] FAIL scoreboard_data: got %h want %h", sampOut, expVal);
          end
        end
      end
      if (sampAcc) expQ.push_back(model(sampIn));
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    load_lut(0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_data !== 20'h0) begin failures++; $display("[TB] FAIL reset_out_data: got %h want 00000", out_data); end
    checks++;
    if (lut_addr_a !== 4'd0 || lut_addr_b !== 4'd0) begin
      failures++; $display("[TB] FAIL reset_addr: got %0d/%0d want 0/0", lut_addr_a, lut_addr_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_single();
    vecs[0]  = '{0, 16'h0000, 4'd8,  4'd9,  20'h08000};
    vecs[1]  = '{0, 16'h0400, 4'd8,  4'd9,  20'h08800};
    vecs[2]  = '{1, 16'h0400, 4'd8,  4'd9,  20'hF7800};
    vecs[3]  = '{4, 16'h0001, 4'd8,  4'd9,  20'hFA23E};
    vecs[4]  = '{0, 16'h3800, 4'd15, 4'd15, 20'h03800};
    vecs[5]  = '{0, 16'h7FFF, 4'd15, 4'd15, 20'h07FFF};
    vecs[6]  = '{0, 16'hBFFF, 4'd0,  4'd0,  20'h00000};
    vecs[7]  = '{0, 16'h8000, 4'd0,  4'd0,  20'h00000};
    vecs[8]  = '{3, 16'hC000, 4'd0,  4'd1,  20'h00064};
    vecs[9]  = '{3, 16'h37FF, 4'd14, 4'd15, 20'h0F062};
    vecs[10] = '{0, 16'hFFFF, 4'd7,  4'd8,  20'h07FFE};
    for (int i = 0; i < 11; i++) begin
      load_lut(vecs[i].mode);
      in_valid = 1'b1; in_data = vecs[i].x; out_ready = 1'b1;
      #1;
      checks++;
      if (lut_addr_a !== vecs[i].a) begin
        failures++; $display("[TB] FAIL addr_a x=%h: got %0d want %0d", vecs[i].x, lut_addr_a, vecs[i].a);
      end
      checks++;
      if (lut_addr_b !== vecs[i].b) begin
        failures++; $display("[TB] FAIL addr_b x=%h: got %0d want %0d", vecs[i].x, lut_addr_b, vecs[i].b);
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #4;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL early_valid x=%h: got %b want 0", vecs[i].x, out_valid); end
      @(negedge clk);
      #4;
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL latency x=%h: got out_valid %b want 1", vecs[i].x, out_valid); end
      checks++;
      if (out_data !== vecs[i].y) begin
        failures++; $display("[TB] FAIL single_data x=%h: got %h want %h", vecs[i].x, out_data, vecs[i].y);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic [15:0] xs [5];
    logic [19:0] ys [5];
    logic [19:0] held;
    int sent, popped;
    xs = '{16'h0000, 16'h0400, 16'h0800, 16'h0C00, 16'h1000};
    ys = '{20'h08000, 20'h08800, 20'h09000, 20'h09800, 20'h0A000};
    load_lut(0);
    sent = 0; popped = 0; held = '0;
    for (int c = 0; c < 15; c++) begin
      out_ready = !(c >= 2 && c <= 6);
      in_valid  = (sent < 5);
      in_data   = (sent < 5) ? xs[sent] : 16'h0;
      #4;
      checks++;
      if (in_ready !== !(c >= 3 && c <= 6)) begin
        failures++; $display("[TB] FAIL stall_in_ready c=%0d: got %b want %b", c, in_ready, !(c >= 3 && c <= 6));
      end
      if (c == 3) held = out_data;
      if (c >= 4 && c <= 6) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          failures++; $display("[TB] FAIL stall_hold c=%0d: got %b/%h want 1/%h", c, out_valid, out_data, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (popped >= 5 || out_data !== ys[popped % 5]) begin
          failures++; $display("[TB] FAIL stall_order pop=%0d: got %h want %h", popped, out_data, ys[popped % 5]);
        end
        popped++;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (popped != 5) begin failures++; $display("[TB] FAIL stall_count: got %0d results want 5", popped); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] xs [16];
    load_lut(2);
    for (int i = 0; i < 16; i++) xs[i] = 16'($urandom_range(0, 65535));
    xs[0] = 16'hC000; xs[1] = 16'h37FF; xs[2] = 16'h3800; xs[3] = 16'hBFFF;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 16);
      in_data  = (c < 16) ? xs[c] : 16'h0;
      #4;
      if (c < 16) begin
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_in_ready c=%0d: got %b want 1", c, in_ready); end
      end
      checks++;
      if (out_valid !== (c >= 3 && c < 19)) begin
        failures++; $display("[TB] FAIL b2b_valid c=%0d: got %b want %b", c, out_valid, (c >= 3 && c < 19));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_gelu();
    logic [15:0] xs [2];
    logic [19:0] ys [2];
    int got;
    xs = '{16'h1000, 16'hEB33};
    ys = '{20'd3446, 20'hFFE06};
    load_lut(2);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = xs[i];
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #4;
      got = int'($signed(out_data)) - int'($signed(ys[i]));
      checks++;
      if (out_valid !== 1'b1 || got > 1 || got < -1) begin
        failures++; $display("[TB] FAIL gelu x=%h: got %b/%h want 1/%h (+-1)", xs[i], out_valid, out_data, ys[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] xs [3];
    xs = '{16'h0000, 16'h0400, 16'h0800};
    load_lut(0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = xs[c];
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL midrst_pre: got out_valid %b want 1", out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    expQ.delete();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 20'h0) begin
      failures++; $display("[TB] FAIL midrst_clear: got %b/%h want 0/00000", out_valid, out_data);
    end
    checks++;
    if (lut_addr_a !== 4'd0 || lut_addr_b !== 4'd0) begin
      failures++; $display("[TB] FAIL midrst_addr: got %0d/%0d want 0/0", lut_addr_a, lut_addr_b);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #4;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++; $display("[TB] FAIL midrst_stale c=%0d: got valid %b ready %b want 0 1", c, out_valid, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b1; in_data = 16'h0400;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #4;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_early: got out_valid %b want 0", out_valid); end
    @(negedge clk);
    #4;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 20'h08800) begin
      failures++; $display("[TB] FAIL midrst_next: got %b/%h want 1/08800", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_drain();
    int budget;
    in_valid = 1'b0; out_ready = 1'b1;
    budget = 0;
    while (expQ.size() != 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      failures++; $display("[TB] FAIL drain: got %0d results outstanding want 0", expQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_gelu();
    test_reset_midstream();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
